// File: rtl/led_seq_pkg.sv
// Shared state encoding and AXI constants for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_ISSUE,
    ST_WAIT_B
  } led_seq_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY        = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR      = 2'b10;
  localparam logic [31:0] LED_REG_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/led_seq_timer.sv
// Pattern period timer: counts while run is high, restarting at 0 whenever run drops,
// and emits a registered one-cycle tick when the count reaches max(period,1)-1.
module led_seq_timer (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        run,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic [31:0] last_cnt;

  always_comb begin
    last_cnt = (period == 32'd0) ? 32'd0 : period - 32'd1;
    cnt_d    = 32'd0;
    tick_d   = 1'b0;
    if (run) begin
      if (cnt_q == last_cnt) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q  <= 32'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Steps through a pattern table, writing one entry per period to the LED register over AXI4-Lite.
//   state      | meaning
//   IDLE       | sequencer stopped, cur_idx retained
//   WAIT_TICK  | period timer running toward next write
//   ISSUE      | AW/W channels valid until each handshakes
//   WAIT_B     | BREADY high, waiting for write response
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] LED_REG_ADDR = C_M_AXI_ADDR_WIDTH'(LED_REG_ADDR_DEFAULT),
  parameter int unsigned NUM_PATTERNS = 8,
  localparam int unsigned IDX_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            enable,
  input  logic [31:0]                     period,
  input  logic                            cfg_we,
  input  logic [IDX_W-1:0]                cfg_idx,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cfg_data,
  input  logic                            err_clr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic                            busy,
  output logic                            err,
  output logic [IDX_W-1:0]                cur_idx
);

  led_seq_state_e                state_q, state_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          err_q, err_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] tbl_q [NUM_PATTERNS];
  logic                          tick;

  led_seq_timer u_timer (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .run    (state_q == ST_WAIT_TICK),
    .period (period),
    .tick   (tick)
  );

  // Table is deliberately outside reset so patterns survive a sequencer reset.
  always_ff @(posedge ACLK) begin
    if (cfg_we) begin
      tbl_q[cfg_idx] <= cfg_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    err_d     = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          state_d   = ST_ISSUE;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          wdata_d   = tbl_q[idx_q];
        end
      end
      ST_ISSUE: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (M_AXI_BVALID) begin
          idx_d   = (idx_q == IDX_W'(NUM_PATTERNS - 1)) ? '0 : idx_q + IDX_W'(1);
          state_d = enable ? ST_WAIT_TICK : ST_IDLE;
          // A failing response overrides a simultaneous clear.
          if (M_AXI_BRESP != AXI_RESP_OKAY) err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

  assign M_AXI_AWADDR  = LED_REG_ADDR;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == ST_WAIT_B);
  assign busy          = (state_q == ST_ISSUE) || (state_q == ST_WAIT_B);
  assign err           = err_q;
  assign cur_idx       = idx_q;

endmodule
